lenet_frame_downscaler: RTL and testbench



---
 rtl/lenet_frame_downscaler_if.sv | 22 ++
 rtl/lenet_frame_downscaler.sv | 188 ++++++++++++++++++
 tb/tb_lenet_frame_downscaler.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lenet_frame_downscaler_if.sv
// Bundles the start/status handshake, the frame-memory read port and the output RAM
// write port of the LeNet frame downscaler.
interface lenet_frame_downscaler_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [18:0] addr_mem0;
  logic [7:0]  din;
  logic [9:0]  addr_out;
  logic [7:0]  dout;
  logic        we;

  modport master (
    output start, din,
    input  busy, done, addr_mem0, addr_out, dout, we
  );

  modport slave (
    input  start, din,
    output busy, done, addr_mem0, addr_out, dout, we
  );
endinterface

// File: rtl/lenet_frame_downscaler.sv
// Box-averages a centred window of the captured frame into an OUT_DIM x OUT_DIM image,
// one band of BLK source rows at a time, and writes it into the LeNet input RAM.
module lenet_frame_downscaler #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int X_OFF      = 96,
  parameter int Y_OFF      = 16,
  parameter int BLK        = 16,
  parameter int OUT_DIM    = 28,
  parameter int RD_LATENCY = 1
) (
  input logic clk25,
  input logic rst_n,
  lenet_frame_downscaler_if.slave bus
);
  localparam int LOG2_BLK = $clog2(BLK);
  localparam int SPAN     = BLK * OUT_DIM;
  localparam int COL_W    = $clog2(SPAN);
  localparam int ROW_W    = (LOG2_BLK > 0) ? LOG2_BLK : 1;
  localparam int K_W      = $clog2(OUT_DIM);
  localparam int CNT_W    = (OUT_DIM >= RD_LATENCY) ? K_W : $clog2(RD_LATENCY);
  localparam int ACC_W    = 8 + 2 * LOG2_BLK;

  if ((X_OFF + SPAN > WIDTH) || (Y_OFF + SPAN > HEIGHT)) begin : g_bad_window
    $error("lenet_frame_downscaler: window does not fit inside the source frame");
  end
  if ((BLK < 2) || ((BLK & (BLK - 1)) != 0)) begin : g_bad_blk
    $error("lenet_frame_downscaler: BLK must be a power of two");
  end
  if (RD_LATENCY < 1) begin : g_bad_latency
    $error("lenet_frame_downscaler: RD_LATENCY must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, FIN} state_e;

  state_e             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [K_W-1:0]     band_q, band_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [18:0]        addr_q, addr_d;
  logic               clr_acc;
  logic [ACC_W-1:0]   acc_q [OUT_DIM];
  logic [ACC_W-1:0]   acc_d [OUT_DIM];
  logic               vld_q [RD_LATENCY];
  logic [K_W-1:0]     tag_q [RD_LATENCY];

  logic [COL_W-1:0]   col_inc;
  logic [ROW_W-1:0]   row_inc;
  logic [K_W-1:0]     band_inc;
  logic [K_W-1:0]     wr_k;

  assign col_inc  = col_q + COL_W'(1);
  assign row_inc  = row_q + ROW_W'(1);
  assign band_inc = band_q + K_W'(1);
  assign wr_k     = K_W'(cnt_q);
  assign bus.addr_mem0 = addr_q;

  function automatic logic [18:0] addr_of(input logic [K_W-1:0] b,
                                          input logic [ROW_W-1:0] r,
                                          input logic [COL_W-1:0] c);
    logic [18:0] line;
    line = 19'(Y_OFF) + (19'(b) << LOG2_BLK) + 19'(r);
    return line * 19'(WIDTH) + 19'(X_OFF) + 19'(c);
  endfunction

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      band_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        tag_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      band_q  <= band_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      for (int i = 0; i < OUT_DIM; i++) acc_q[i] <= acc_d[i];
      // The address on addr_mem0 this cycle belongs to the tag pushed this cycle.
      vld_q[0] <= (state_q == READ);
      tag_q[0] <= K_W'(col_q >> LOG2_BLK);
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    band_d       = band_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    clr_acc      = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.we       = 1'b0;
    bus.addr_out = '0;
    bus.dout     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = READ;
          col_d   = '0;
          row_d   = '0;
          band_d  = '0;
          cnt_d   = '0;
          clr_acc = 1'b1;
          addr_d  = addr_of('0, '0, '0);
        end
      end
      READ: begin
        bus.busy = 1'b1;
        if (col_q == COL_W'(SPAN - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(BLK - 1)) begin
            row_d   = '0;
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            row_d  = row_inc;
            addr_d = addr_of(band_q, row_inc, '0);
          end
        end else begin
          col_d  = col_inc;
          addr_d = addr_of(band_q, row_q, col_inc);
        end
      end
      DRAIN: begin
        bus.busy = 1'b1;
        if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
          cnt_d   = '0;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        bus.busy     = 1'b1;
        bus.we       = 1'b1;
        bus.addr_out = 10'(band_q) * 10'(OUT_DIM) + 10'(wr_k);
        bus.dout     = 8'(acc_q[wr_k] >> (2 * LOG2_BLK));
        if (cnt_q == CNT_W'(OUT_DIM - 1)) begin
          cnt_d = '0;
          if (band_q == K_W'(OUT_DIM - 1)) begin
            state_d = FIN;
          end else begin
            band_d  = band_inc;
            addr_d  = addr_of(band_inc, '0, '0);
            state_d = READ;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A column's accumulator is emptied in the same cycle it is written out, so the next
  // band starts from zero without a separate clearing pass.
  always_comb begin
    for (int i = 0; i < OUT_DIM; i++) begin
      acc_d[i] = acc_q[i];
      if (clr_acc || (state_q == WRITE && wr_k == K_W'(i))) begin
        acc_d[i] = '0;
      end else if (vld_q[RD_LATENCY-1] && tag_q[RD_LATENCY-1] == K_W'(i)) begin
        acc_d[i] = acc_q[i] + ACC_W'(bus.din);
      end
    end
  end
endmodule

// File: tb/tb_lenet_frame_downscaler.sv
// Directed bench for lenet_frame_downscaler on a reduced 64x48 frame (4x4 blocks, 8x8 output)
// so that several complete frames fit in a short run; a second instance uses RD_LATENCY=3.
module tb_lenet_frame_downscaler;
  localparam int WIDTH   = 64;
  localparam int HEIGHT  = 48;
  localparam int X_OFF   = 16;
  localparam int Y_OFF   = 8;
  localparam int BLK     = 4;
  localparam int OUT_DIM = 8;
  localparam int SPAN    = BLK * OUT_DIM;
  localparam int NPIX    = OUT_DIM * OUT_DIM;
  // 1 + 8*(4*4*8 + L + 8) for L = 1 and L = 3
  localparam int LAT1 = 1097;
  localparam int LAT3 = 1113;
  // (8+0)*64+16 and (8+31)*64+16+31
  localparam int FIRST_ADDR = 528;
  localparam int LAST_ADDR  = 2543;

  logic clk25;
  logic rst_n;
  int   assertCount;
  int   failCount;
  logic [7:0] frame [WIDTH*HEIGHT];
  logic [7:0] stage1 [1];
  logic [7:0] stage3 [3];

  lenet_frame_downscaler_if bus1 ();
  lenet_frame_downscaler_if bus3 ();

  lenet_frame_downscaler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .BLK(BLK), .OUT_DIM(OUT_DIM), .RD_LATENCY(1)
  ) dut1 (
    .clk25(clk25),
    .rst_n(rst_n),
    .bus(bus1)
  );

  lenet_frame_downscaler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_OFF(X_OFF), .Y_OFF(Y_OFF),
    .BLK(BLK), .OUT_DIM(OUT_DIM), .RD_LATENCY(3)
  ) dut3 (
    .clk25(clk25),
    .rst_n(rst_n),
    .bus(bus3)
  );

  always #5 clk25 = ~clk25;

  function automatic logic [7:0] readMem(input logic [18:0] a);
    if (a < 19'(WIDTH * HEIGHT)) return frame[a[11:0]];
    return 8'hFF;
  endfunction

  // Frame memory read ports, clocked on the inverted clock like the real memory.
  always @(negedge clk25) begin
    bus1.din  = stage1[0];
    stage1[0] = readMem(bus1.addr_mem0);
    bus3.din  = stage3[2];
    stage3[2] = stage3[1];
    stage3[1] = stage3[0];
    stage3[0] = readMem(bus3.addr_mem0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] pixelOf(input int mode, input int x, input int y);
    int  wx, wy;
    bit  inWin;
    wx = x - X_OFF;
    wy = y - Y_OFF;
    inWin = (wx >= 0) && (wx < SPAN) && (wy >= 0) && (wy < SPAN);
    case (mode)
      0: return 8'h80;
      1: return inWin ? 8'((wx / BLK) * 9) : 8'hFF;
      default: begin
        if (!inWin) return 8'h00;
        if ((((wx / BLK) + (wy / BLK)) % 2 == 1) && (wx % BLK == 0) && (wy % BLK == 0))
          return 8'h00;
        return 8'hFF;
      end
    endcase
  endfunction

  // Hand-derived block means: 0x80 flat; k*9 per column block; 15*255/16 -> 0xEF.
  function automatic logic [7:0] expPixel(input int mode, input int band, input int k);
    case (mode)
      0: return 8'h80;
      1: return 8'(k * 9);
      default: return (((band + k) % 2) == 1) ? 8'hEF : 8'hFF;
    endcase
  endfunction

  task automatic loadFrame(input int mode);
    for (int y = 0; y < HEIGHT; y++)
      for (int x = 0; x < WIDTH; x++)
        frame[y*WIDTH + x] = pixelOf(mode, x, y);
  endtask

  task automatic applyStimulus(input int sel, input logic v);
    if (sel == 1) bus3.start = v;
    else bus1.start = v;
  endtask

  task automatic runFrame(input int sel, input int mode, input int latency, input bit rePulse);
    int wrIdx, doneAt, donePulses;
    logic busyAtDone, busyAfter;
    logic obsWe, obsBusy, obsDone;
    logic [9:0] obsAddrOut;
    logic [7:0] obsDout;
    logic [31:0] obsAddr, minAddr, maxAddr;
    loadFrame(mode);
    wrIdx = 0; doneAt = -1; donePulses = 0;
    busyAtDone = 1'b0; busyAfter = 1'b1;
    minAddr = 32'hFFFF_FFFF; maxAddr = 0;
    for (int idx = 0; idx <= latency + 4; idx++) begin
      @(negedge clk25);
      applyStimulus(sel, (idx == 0) || (rePulse && (idx == 10 || idx == latency)));
      obsWe      = (sel == 1) ? bus3.we        : bus1.we;
      obsBusy    = (sel == 1) ? bus3.busy      : bus1.busy;
      obsDone    = (sel == 1) ? bus3.done      : bus1.done;
      obsAddrOut = (sel == 1) ? bus3.addr_out  : bus1.addr_out;
      obsDout    = (sel == 1) ? bus3.dout      : bus1.dout;
      obsAddr    = 32'((sel == 1) ? bus3.addr_mem0 : bus1.addr_mem0);
      if (obsBusy) begin
        if (obsAddr < minAddr) minAddr = obsAddr;
        if (obsAddr > maxAddr) maxAddr = obsAddr;
      end
      if (obsWe) begin
        if (wrIdx < NPIX) begin
          checkOutput("addr_out", 32'(obsAddrOut), 32'(wrIdx));
          checkOutput("dout", 32'(obsDout), 32'(expPixel(mode, wrIdx / OUT_DIM, wrIdx % OUT_DIM)));
        end
        wrIdx++;
      end
      if (obsDone) begin
        donePulses++;
        if (doneAt < 0) doneAt = idx;
        busyAtDone = obsBusy;
      end
      if (idx == latency + 1) busyAfter = obsBusy;
    end
    checkOutput("writeCount", 32'(wrIdx), 32'(NPIX));
    checkOutput("doneCycle", 32'(doneAt), 32'(latency));
    checkOutput("donePulses", 32'(donePulses), 1);
    checkOutput("busyAtDone", 32'(busyAtDone), 1);
    checkOutput("busyAfterDone", 32'(busyAfter), 0);
    checkOutput("firstPixelAddr", minAddr, FIRST_ADDR);
    checkOutput("lastPixelAddr", maxAddr, LAST_ADDR);
  endtask

  task automatic runResetAbort();
    bit hit, postChecked;
    int weAfter, doneAfter;
    loadFrame(0);
    hit = 1'b0; postChecked = 1'b0; weAfter = 0; doneAfter = 0;
    for (int idx = 0; idx <= LAT1 + 4; idx++) begin
      @(negedge clk25);
      applyStimulus(0, idx == 0);
      if (hit && !postChecked) begin
        checkOutput("weAfterReset", 32'(bus1.we), 0);
        checkOutput("busyAfterReset", 32'(bus1.busy), 0);
        checkOutput("doneAfterReset", 32'(bus1.done), 0);
        rst_n = 1'b1;
        postChecked = 1'b1;
      end else if (postChecked) begin
        if (bus1.we) weAfter++;
        if (bus1.done) doneAfter++;
      end else if (bus1.we && bus1.addr_out == 10'(3 * OUT_DIM + 2)) begin
        rst_n = 1'b0;
        hit = 1'b1;
      end
    end
    rst_n = 1'b1;
    checkOutput("band3WriteReached", 32'(postChecked), 1);
    checkOutput("writesAfterAbort", 32'(weAfter), 0);
    checkOutput("donesAfterAbort", 32'(doneAfter), 0);
  endtask

  initial begin
    clk25 = 1'b0;
    rst_n = 1'b0;
    assertCount = 0;
    failCount = 0;
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    bus1.din = '0;
    bus3.din = '0;
    stage1[0] = '0;
    for (int i = 0; i < 3; i++) stage3[i] = '0;
    loadFrame(0);

    repeat (3) @(negedge clk25);
    checkOutput("resetBusy", 32'(bus1.busy), 0);
    checkOutput("resetDone", 32'(bus1.done), 0);
    checkOutput("resetWe", 32'(bus1.we), 0);
    checkOutput("resetAddrMem", 32'(bus1.addr_mem0), 0);
    checkOutput("resetAddrOut", 32'(bus1.addr_out), 0);
    checkOutput("resetDout", 32'(bus1.dout), 0);
    checkOutput("resetBusyL3", 32'(bus3.busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk25);

    $display("[TB] uniform frame");
    runFrame(0, 0, LAT1, 1'b0);
    $display("[TB] column-ramp frame");
    runFrame(0, 1, LAT1, 1'b0);
    $display("[TB] truncation and saturation blocks");
    runFrame(0, 2, LAT1, 1'b0);
    $display("[TB] start re-pulsed mid-frame and at FIN, then restart 5 cycles after done");
    runFrame(0, 1, LAT1, 1'b1);
    runFrame(0, 1, LAT1, 1'b0);
    $display("[TB] reset during band 3 write, then a full frame");
    runResetAbort();
    repeat (2) @(negedge clk25);
    runFrame(0, 1, LAT1, 1'b0);
    $display("[TB] read latency 3 instance");
    runFrame(1, 1, LAT3, 1'b0);
    runFrame(1, 2, LAT3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
